// File: rtl/counter_run_controller.sv
// Run/direction sequencer for the 4-bit count / Fibonacci / 7-segment datapath.
// Optional `FIB_PAUSE_EN: dwell FIB_HOLD extra ticks on each Fibonacci count.
module counter_run_controller #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned DEB_CYCLES = 3,
  parameter int unsigned FIB_HOLD   = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_switch_in,
  input  logic       i_run_in,
  input  logic [3:0] i_count_in,
  input  logic       i_fib_in,
  output logic       o_switch_out,
  output logic       o_count_en,
  output logic       o_count_dir,
  output logic       o_count_clr,
  output logic [1:0] o_state,
  output logic       o_tick,
  output logic       o_wrap_pulse
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRunUp   = 2'b01,
    StRunDown = 2'b10,
    StHold    = 2'b11
  } state_e;

  state_e        r_state;
  logic          r_dir;
  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_deb_cnt;
  logic          r_switch;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          w_running;
  logic          w_run_state;
  logic          w_fib_suppress;

  // Switch synchronizer and debounce: count consecutive disagreeing cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb_cnt <= '0;
      r_switch  <= 1'b0;
    end else begin
      r_sync1 <= i_switch_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_switch) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_switch  <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  // Prescaler stops as soon as the FSM is (or is about to be) idle.
  assign w_running = (r_state != StIdle) && i_run_in;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_running && (r_presc == TICK_LAST);
      if (!w_running || (r_presc == TICK_LAST)) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // run_in low wins over every other transition.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_run_in) begin
            r_state <= r_switch ? StRunDown : StRunUp;
            r_dir   <= r_switch;
          end
        end
        StRunUp: begin
          if (!i_run_in) begin
            r_state <= StIdle;
          end else if (r_switch) begin
            r_state <= StHold;
          end
        end
        StRunDown: begin
          if (!i_run_in) begin
            r_state <= StIdle;
          end else if (!r_switch) begin
            r_state <= StHold;
          end
        end
        StHold: begin
          if (!i_run_in) begin
            r_state <= StIdle;
          end else if (r_tick) begin
            r_state <= r_switch ? StRunDown : StRunUp;
            r_dir   <= r_switch;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_run_state = (r_state == StRunUp) || (r_state == StRunDown);

`ifdef FIB_PAUSE_EN
  localparam int unsigned HW = (FIB_HOLD > 0) ? $clog2(FIB_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(FIB_HOLD);

  logic [HW-1:0] r_hold;

  assign w_fib_suppress = i_fib_in && (r_hold < HOLD_MAX);

  // Counts ticks swallowed on the current Fibonacci value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold <= '0;
    end else if ((r_state == StIdle) || o_count_en) begin
      r_hold <= '0;
    end else if (r_tick && w_run_state && w_fib_suppress) begin
      r_hold <= r_hold + HW'(1);
    end
  end
`else
  logic w_unused_fib;
  assign w_unused_fib   = i_fib_in;
  assign w_fib_suppress = 1'b0;
`endif

  assign o_count_en   = r_tick && w_run_state && !w_fib_suppress;
  assign o_wrap_pulse = o_count_en && (((r_state == StRunUp) && (i_count_in == 4'd15)) ||
                                       ((r_state == StRunDown) && (i_count_in == 4'd0)));
  assign o_count_clr  = (r_state == StIdle);
  assign o_count_dir  = r_dir;
  assign o_state      = r_state;
  assign o_tick       = r_tick;
  assign o_switch_out = r_switch;

endmodule

// File: doc/counter_run_controller.md
Name: counter_run_controller

Overview:
- Sequencing controller for the 4-bit count / Fibonacci-detect / 7-segment datapath.
- Debounces the direction switch and generates the counter's tick-rate enable.
- Runs an FSM that drives the counter's enable, direction and clear.
- Optionally dwells on Fibonacci values so they stay on the display longer.

Parameters:
- TICK_DIV, 4: clk cycles per count tick; must be at least 2.
- DEB_CYCLES, 3: consecutive stable synchronized cycles required before the debounced switch changes.
- FIB_HOLD, 2: extra ticks spent on a Fibonacci value (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- switch_in  in  1  raw direction switch; 0 = up, 1 = down.
- run_in  in  1  level run enable.
- count_in  in  4  current counter value fed back from the datapath.
- fib_in  in  1  datapath Fibonacci flag for count_in.
- switch_out  out  1  debounced switch.
- count_en  out  1  counter advance strobe.
- count_dir  out  1  0 = increment, 1 = decrement.
- count_clr  out  1  synchronous clear request to the counter.
- state  out  2  FSM state encoding.
- tick  out  1  prescaler pulse.
- wrap_pulse  out  1  counter is wrapping on this edge.

Behaviour:
- Reset values (async, active-high): state=00 IDLE, switch_out=0, tick=0, count_en=0, count_dir=0, count_clr=1, wrap_pulse=0. Synchronizer, debounce counter, prescaler and hold counter all reset to 0.
- Switch path:
  - switch_in passes through a 2-FF synchronizer.
  - The debounce counter counts consecutive cycles in which the sync value differs from switch_out.
  - switch_out takes the new value when the count reaches DEB_CYCLES.
  - Any return to the old value clears the count.
  - Latency from a clean edge on switch_in to switch_out = 2+DEB_CYCLES cycles.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN_UP, RUN_DOWN or HOLD; held at 0 in IDLE.
  - tick is a registered 1-cycle pulse when the prescaler is at TICK_DIV-1.
  - First tick arrives TICK_DIV cycles after leaving IDLE.
- FSM states (00 IDLE, 01 RUN_UP, 10 RUN_DOWN, 11 HOLD):
  - IDLE: count_clr=1. Moves to RUN_UP if run_in & !switch_out, or to RUN_DOWN if run_in & switch_out.
  - RUN_UP / RUN_DOWN: if run_in=0, go to IDLE. Otherwise, if switch_out no longer matches the current direction, go to HOLD.
  - HOLD: count_en=0 and count_dir keeps the previous direction. If run_in=0, go to IDLE. On tick, go to the run state selected by switch_out.
  - run_in=0 takes priority over every other transition, including a simultaneous switch change.
- Outputs:
  - count_dir is registered: 0 in RUN_UP, 1 in RUN_DOWN, unchanged in HOLD and IDLE.
  - count_en = tick & (state is RUN_UP or RUN_DOWN) & !fib_suppress; combinational, one cycle wide.
  - The counter updates on the clk edge where count_en=1.
  - count_clr = (state==IDLE); Moore output.
  - wrap_pulse = count_en & ((RUN_UP & count_in==15) | (RUN_DOWN & count_in==0)).
  - Wrap arithmetic is the counter's native 4-bit modulo 16; the controller never loads a value.
- Reset mid-run: everything returns to reset values immediately (asynchronously). No tick or count_en is issued until run_in is seen high after reset releases.

Optional Feature:
- Macro: FIB_PAUSE_EN.
- Defined:
  - fib_suppress is active when fib_in=1 and the hold counter < FIB_HOLD.
  - On each tick while suppressed, count_en stays 0 and the hold counter increments.
  - When count_en fires, the hold counter clears; it also clears in IDLE and on reset.
  - Each Fibonacci value therefore lasts FIB_HOLD+1 ticks.
- Undefined: fib_suppress is tied to 0, the hold counter is absent, and fib_in is ignored.

Test Plan:
1. reset=1 for 30 ns, run_in=0 -> state=00, count_clr=1, count_en=0, tick=0, switch_out=0 throughout; held with run_in=0 after release.
2. run_in=1, switch_in=0, TICK_DIV=4 -> state=01 one cycle later; count_en pulses every 4 cycles; counter steps 0..15; wrap_pulse=1 with count_in=15, next value 0.
3. switch_in glitches high for 2 cycles -> switch_out stays 0. switch_in held high -> switch_out=1 after exactly 5 cycles; state goes 01 -> 11, then 10 at the next tick; count_dir=1.
4. In RUN_DOWN, run_in=0 and switch_out toggles on the same cycle -> state=00, count_clr=1, no count_en issued.
5. reset asserted mid-RUN_UP with count_in=7 -> outputs at reset values without waiting for a clk edge; prescaler at 0; after release, first tick comes 4 cycles after run_in is seen.
6. FIB_PAUSE_EN, FIB_HOLD=2, fib_in=1 at count_in=5 -> two ticks with count_en=0, count_en=1 on the third; at count_in=4 (fib_in=0) count_en fires on every tick.
